// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder with valid/ready handshake and multi-cycle M-extension latency modelling.
// Latency: 1 cycle for base/illegal ops, MUL_LAT / DIV_LAT cycles for RV32M ops.
// Backpressure: result holds in VALID until out_ready; in_ready drops while waiting or while stalled.
module alu_ctrl_pipe #(
  parameter int CTRL_W  = 5,
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              opcode5,
  input  logic              funct7_5,
  input  logic              funct7_0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              busy
);

  // Counter sized so the longest latency minus one always fits without wrapping.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic             M_ON    = (EN_M != 0);

  // Operation codes, decoded at 5 bits then zero-extended to CTRL_W.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ill_q, ill_d;

  logic [4:0]        dec_code5;
  logic [CTRL_W-1:0] dec_code;
  logic              dec_ill;
  logic              dec_m;
  logic              dec_div;
  logic              m_pat;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_multi;
  logic              accept;

  // funct7 = 0000001 on an R-type is the M-extension marker.
  assign m_pat = opcode5 & funct7_0 & ~funct7_5;

  // Combinational decode of the request currently on the inputs.
  always_comb begin
    dec_code5 = OP_ADD;
    dec_ill   = 1'b0;
    dec_m     = 1'b0;
    dec_div   = 1'b0;
    case (alu_op)
      2'b00: dec_code5 = OP_ADD;
      2'b01: dec_code5 = OP_SUB;
      2'b10: begin
        if (m_pat) begin
          if (M_ON) begin
            dec_code5 = {2'b10, funct3};
            dec_m     = 1'b1;
            dec_div   = funct3[2];
          end else begin
            dec_ill   = 1'b1;
          end
        end else begin
          case (funct3)
            3'b000:  dec_code5 = (opcode5 & funct7_5) ? OP_SUB : OP_ADD;
            3'b001:  dec_code5 = OP_SLL;
            3'b010:  dec_code5 = OP_SLT;
            3'b011:  dec_code5 = OP_SLTU;
            3'b100:  dec_code5 = OP_XOR;
            3'b101:  dec_code5 = funct7_5 ? OP_SRA : OP_SRL;
            3'b110:  dec_code5 = OP_OR;
            default: dec_code5 = OP_AND;
          endcase
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_code = CTRL_W'(dec_code5);

  // A latency of 1 means a zero count, so the op behaves like a single-cycle one.
  assign m_cnt   = dec_div ? DIV_CNT : MUL_CNT;
  assign m_multi = dec_m & (m_cnt != '0);

  assign in_ready  = (state_q == IDLE) | ((state_q == VALID) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == VALID);
  assign busy      = (state_q == WAIT);

  assign alu_control = ctrl_q;
  assign illegal     = ill_q;

  // Next-state logic: countdown in WAIT, drain in VALID, and a new accept overrides both.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = VALID;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      VALID: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      ctrl_d = dec_code;
      ill_d  = dec_ill;
      if (m_multi) begin
        state_d = WAIT;
        cnt_d   = m_cnt;
      end else begin
        state_d = VALID;
        cnt_d   = '0;
      end
    end
  end

  // State, counter and registered decode result; reset discards any pending op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: transaction-level model compared every cycle plus directed literal checks.
// Latency: model tracks per-op latency as a countdown to a valid time.
// Backpressure: out_ready is toggled to exercise holding and back-to-back transfers.
module tb_alu_ctrl_pipe;

  localparam int CTRL_W  = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, out_ready;
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              opcode5, funct7_5, funct7_0;
  logic              in_ready, out_valid, illegal, busy;
  logic [CTRL_W-1:0] alu_control;

  logic              in_valid2, out_ready2;
  logic              in_ready2, out_valid2, illegal2, busy2;
  logic [CTRL_W-1:0] alu_control2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.CTRL_W(CTRL_W), .EN_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .opcode5(opcode5), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .illegal(illegal), .busy(busy)
  );

  alu_ctrl_pipe #(.CTRL_W(CTRL_W), .EN_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nom (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(alu_op), .funct3(funct3), .opcode5(opcode5), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .out_valid(out_valid2), .out_ready(out_ready2), .alu_control(alu_control2),
    .illegal(illegal2), .busy(busy2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference decode straight from the operation table.
  typedef struct {
    int code;
    bit ill;
    int lat;
  } dec_t;

  function automatic dec_t mdl_decode(input bit en_m, input logic [1:0] aop, input logic [2:0] f3,
                                      input logic op5, input logic f75, input logic f70);
    dec_t r;
    r.code = 0; r.ill = 1'b0; r.lat = 1;
    if (aop == 2'b00)      r.code = 0;
    else if (aop == 2'b01) r.code = 1;
    else if (aop == 2'b11) r.ill = 1'b1;
    else if (op5 && f70 && !f75) begin
      if (en_m) begin
        r.code = 16 + int'(f3);
        r.lat  = (f3 >= 3'd4) ? DIV_LAT : MUL_LAT;
      end else begin
        r.ill  = 1'b1;
      end
    end else begin
      case (f3)
        3'd0: r.code = (op5 && f75) ? 1 : 0;
        3'd1: r.code = 7;
        3'd2: r.code = 5;
        3'd3: r.code = 6;
        3'd4: r.code = 4;
        3'd5: r.code = f75 ? 9 : 8;
        3'd6: r.code = 3;
        default: r.code = 2;
      endcase
    end
    return r;
  endfunction

  // Transaction model: one pending op, valid once its remaining latency reaches zero.
  bit   m_pend = 1'b0;
  int   m_rem  = 0;
  int   m_code = 0;
  bit   m_ill  = 1'b0;
  dec_t d1;
  bit   m_ov, m_busy, m_rdy, m_acc, m_take;

  always_comb begin
    d1     = mdl_decode(1'b1, alu_op, funct3, opcode5, funct7_5, funct7_0);
    m_ov   = m_pend && (m_rem == 0);
    m_busy = m_pend && (m_rem > 0);
    m_rdy  = !m_pend || (m_ov && out_ready);
    m_acc  = in_valid && m_rdy;
    m_take = m_ov && out_ready;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_rem  <= 0;
      m_code <= 0;
      m_ill  <= 1'b0;
    end else if (m_acc) begin
      m_pend <= 1'b1;
      m_rem  <= d1.lat - 1;
      m_code <= d1.code;
      m_ill  <= d1.ill;
    end else begin
      if (m_take) m_pend <= 1'b0;
      if (m_busy) m_rem <= m_rem - 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_in_ready", 32'(in_ready), 32'(m_rdy));
      chk("cyc_alu_control", 32'(alu_control), m_code);
      chk("cyc_illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic send(input logic [7:0] v);
    {alu_op, funct3, opcode5, funct7_5, funct7_0} = v;
    in_valid = 1'b1;
  endtask

  // Counts cycles after accept until out_valid, with busy and in_ready tallies; bounded.
  task automatic measure(output int n, output int bn, output int rn);
    n = 0; bn = 0; rn = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      bn += int'(busy);
      rn += int'(in_ready);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ops [4];
    int         exp_codes [4];
    int         n, bn, rn, cnt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'b000; opcode5 = 1'b0; funct7_5 = 1'b0; funct7_0 = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // R-type SUB
    @(posedge clk); #1;
    send({2'b10, 3'b000, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub_out_valid", 32'(out_valid), 32'd1);
    chk("sub_code", 32'(alu_control), 32'd1);
    chk("sub_illegal", 32'(illegal), 32'd0);

    // Back-to-back stream: SLL, SLTU, SRA, ADDI with funct7_5 set (stays ADD)
    ops[0] = {2'b10, 3'b001, 1'b1, 1'b0, 1'b0}; exp_codes[0] = 7;
    ops[1] = {2'b10, 3'b011, 1'b1, 1'b0, 1'b0}; exp_codes[1] = 6;
    ops[2] = {2'b10, 3'b101, 1'b1, 1'b1, 1'b0}; exp_codes[2] = 9;
    ops[3] = {2'b10, 3'b000, 1'b0, 1'b1, 1'b0}; exp_codes[3] = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send(ops[i]);
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk("stream_out_valid", 32'(out_valid), 32'd1);
        chk("stream_code", 32'(alu_control), exp_codes[i-1]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_out_valid", 32'(out_valid), 32'd1);
    chk("stream_code", 32'(alu_control), exp_codes[3]);

    // DIV: 31 busy cycles, result on cycle 32
    @(posedge clk); #1;
    send({2'b10, 3'b100, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    measure(n, bn, rn);
    chk("div_latency", n, 32'd32);
    chk("div_busy_cycles", bn, 32'd31);
    chk("div_in_ready_cycles", rn, 32'd0);
    chk("div_code", 32'(alu_control), 32'd20);
    chk("div_illegal", 32'(illegal), 32'd0);

    // MULHU: latency 3
    @(posedge clk); #1;
    send({2'b10, 3'b011, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    measure(n, bn, rn);
    chk("mulhu_latency", n, 32'd3);
    chk("mulhu_busy_cycles", bn, 32'd2);
    chk("mulhu_code", 32'(alu_control), 32'd19);

    // ADD held under backpressure while the inputs are scrambled
    @(posedge clk); #1;
    send({2'b00, 3'b000, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    {alu_op, funct3, opcode5, funct7_5, funct7_0} = {2'b10, 3'b101, 1'b1, 1'b1, 1'b0};
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_code", 32'(alu_control), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("take_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Reserved alu_op
    @(posedge clk); #1;
    send({2'b11, 3'b000, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rsv_out_valid", 32'(out_valid), 32'd1);
    chk("rsv_code", 32'(alu_control), 32'd0);
    chk("rsv_illegal", 32'(illegal), 32'd1);

    // MUL pattern: legal on the M-enabled instance, illegal without M
    @(posedge clk); #1;
    send({2'b10, 3'b000, 1'b1, 1'b0, 1'b1});
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("nom_mul_out_valid", 32'(out_valid2), 32'd1);
    chk("nom_mul_illegal", 32'(illegal2), 32'd1);
    chk("nom_mul_code", 32'(alu_control2), 32'd0);
    chk("m_mul_busy", 32'(busy), 32'd1);
    chk("m_mul_illegal", 32'(illegal), 32'd0);
    chk("m_mul_code", 32'(alu_control), 32'd16);
    repeat (4) @(posedge clk);
    #1;
    {alu_op, funct3, opcode5, funct7_5, funct7_0} = {2'b10, 3'b010, 1'b1, 1'b0, 1'b0};
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("nom_slt_illegal", 32'(illegal2), 32'd0);
    chk("nom_slt_code", 32'(alu_control2), 32'd5);

    // Reset in the middle of a DIV wait
    @(posedge clk); #1;
    send({2'b10, 3'b101, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_code", 32'(alu_control), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("midrst_no_output", cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameters, one per line:
- CTRL_W, 5, alu_control width; values <5 are illegal.
- EN_M, 1, enables RV32M decode when 1.
- MUL_LAT, 3, result-valid latency for MUL* ops in cycles; >=1.
- DIV_LAT, 32, result-valid latency for DIV/REM ops in cycles; >=1.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  decode request present.
- in_ready  out  1  block accepts request this cycle.
- alu_op  in  2  main-decoder class: 00 add, 01 sub/branch, 10 funct-decoded, 11 reserved.
- funct3  in  3  instruction funct3.
- opcode5  in  1  opcode bit 5 (1 = R-type).
- funct7_5  in  1  funct7 bit 5.
- funct7_0  in  1  funct7 bit 0 (M-extension marker).
- out_valid  out  1  alu_control/illegal valid.
- out_ready  in  1  consumer takes output this cycle.
- alu_control  out  CTRL_W  ALU operation code.
- illegal  out  1  request was undecodable.
- busy  out  1  multi-cycle op counting.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 Encoding SHALL be: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, M ops 16+funct3 (MUL 16 .. REMU 23); zero-extended to CTRL_W.
REQ-005 alu_op 00 -> ADD; 01 -> SUB.
REQ-006 alu_op 10, non-M: funct3 000 -> SUB iff opcode5&funct7_5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA iff funct7_5 else SRL; 110 OR; 111 AND.
REQ-007 M op iff alu_op=10 & opcode5 & funct7_0 & !funct7_5 & EN_M=1; funct3 0xx MUL class, 1xx DIV class.
REQ-008 alu_op 11, or M pattern with EN_M=0, SHALL yield alu_control=ADD, illegal=1; otherwise illegal=0.
REQ-009 Transfer occurs on in_valid&in_ready (accept) and out_valid&out_ready (take), sampled at rising clk.
REQ-010 FSM states IDLE, WAIT, VALID. in_ready = IDLE | (VALID & out_ready); in_ready=0 in WAIT.
REQ-011 Accept of non-M or illegal op SHALL go to VALID; out_valid high the cycle after accept (latency 1).
REQ-012 Accept of M op with lat L (MUL_LAT or DIV_LAT): L=1 -> VALID; else WAIT with counter loaded L-1, decrement each cycle, VALID when counter reaches 1->0 transition; out_valid first high exactly L cycles after accept.
REQ-013 busy SHALL equal (state==WAIT).
REQ-014 VALID & take & !accept -> IDLE; VALID & take & accept -> new op loaded per REQ-011/012 (back-to-back, 1 op/cycle for single-cycle ops).
REQ-015 VALID & !out_ready: alu_control, illegal SHALL hold stable; in_ready=0.
REQ-016 Decode result SHALL be registered at accept; input changes afterward SHALL NOT affect outputs.
REQ-017 Counter width SHALL be clog2(max(MUL_LAT,DIV_LAT))+1; no wrap permitted.

Reset
REQ-018 rst_n low SHALL immediately force state IDLE, out_valid 0, alu_control 0, illegal 0, busy 0, counter 0; in_ready 1 after release.
REQ-019 Reset mid-WAIT or mid-VALID SHALL discard the pending op; no out_valid follows.

Verification
REQ-020 alu_op=10, funct3=000, opcode5=1, funct7_5=1, out_ready=1 -> next cycle out_valid=1, alu_control=1, illegal=0.
REQ-021 Stream of 4 single-cycle ops, out_ready=1 -> in_ready stays 1, 4 consecutive out_valid cycles, codes in order.
REQ-022 DIV (funct3=100, funct7_0=1, opcode5=1), DIV_LAT=32 -> busy 31 cycles, in_ready=0, out_valid at cycle 32, alu_control=20.
REQ-023 ADD result with out_ready=0 for 5 cycles -> alu_control=0 stable, in_ready=0; out_ready=1 -> take, back to IDLE.
REQ-024 alu_op=11 -> alu_control=0, illegal=1; EN_M=0 with MUL pattern -> illegal=1.
REQ-025 rst_n low at WAIT cycle 10 of DIV -> busy=0, out_valid=0 immediately; no output after release.
